anton_neopixel_stream_serializer: RTL and testbench

Downstream consumer of the neopixel register/frame-buffer stage. It walks the frame buffer through the two-port RAM read port, serialises each byte MSB-first into the WS2812-style one-wire waveform, and appends the latch (reset) low period. At frame end it pulses `streamSyncOf` back to the register block, which then clears or keeps `regCtrlRun` for loop mode.

---
 rtl/anton_neopixel_stream_serializer_if.sv | 13 +
 rtl/anton_neopixel_stream_serializer.sv | 139 +++++++++++++
 tb/tb_anton_neopixel_stream_serializer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/anton_neopixel_stream_serializer_if.sv
// rtl/anton_neopixel_stream_serializer_if.sv - frame-buffer RAM read port bundle
// Serializer drives the read address; the RAM returns data one cycle later.
interface anton_neopixel_stream_serializer_if #(
  parameter int BUFFER_END = 15
);
  localparam int BUFFER_BITS = $clog2(BUFFER_END + 1);

  logic [BUFFER_BITS-1:0] pixelIndexComb;
  logic [7:0]             pixelVal;

  modport master (output pixelIndexComb, input  pixelVal);
  modport slave  (input  pixelIndexComb, output pixelVal);
endinterface

// File: rtl/anton_neopixel_stream_serializer.sv
// rtl/anton_neopixel_stream_serializer.sv - WS2812-style one-wire frame serializer
// Walks the frame buffer, emits each byte MSB-first, then a low latch period.
module anton_neopixel_stream_serializer #(
  parameter int BUFFER_END  = 15,
  parameter int BIT_TICKS   = 9,
  parameter int T0H         = 3,
  parameter int T1H         = 6,
  parameter int RESET_TICKS = 400
) (
  input  logic                                busClk,
  input  logic                                syncReset,
  anton_neopixel_stream_serializer_if.master  ram,
  input  logic [12:0]                         regMax,
  input  logic                                regCtrlInit,
  input  logic                                regCtrlLimit,
  input  logic                                regCtrlRun,
  input  logic                                regCtrl32bit,
  output logic                                neoData,
  output logic                                streamSyncOf,
  output logic                                state
);
  localparam int BUFFER_BITS = $clog2(BUFFER_END + 1);
  localparam int TW = $clog2(BIT_TICKS + 1);
  localparam int LW = $clog2(RESET_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST  = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] T0_TICKS   = TW'(T0H);
  localparam logic [TW-1:0] T1_TICKS   = TW'(T1H);
  localparam logic [LW-1:0] LATCH_LAST = LW'(RESET_TICKS - 1);
  localparam logic [LW-1:0] LATCH_PRE  = LW'(RESET_TICKS - 2);
  localparam logic [12:0]   CAP8_LAST  = 13'(BUFFER_END);
  localparam logic [12:0]   CAP32_LAST = 13'(BUFFER_END >> 2);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_LATCH} state_t;

  state_t                 r_state;
  logic [TW-1:0]          r_tick;
  logic [2:0]             r_bit;
  logic [7:0]             r_shift;
  logic [LW-1:0]          r_lcnt;
  logic [BUFFER_BITS-1:0] r_elem;
  logic [BUFFER_BITS-1:0] r_end;
  logic                   r_mode;
  logic                   r_last;
  logic                   r_hold;

  logic [12:0]            w_cap_last;
  logic [BUFFER_BITS-1:0] w_end_idx;
  logic                   w_bit_val;
  logic [TW-1:0]          w_tick_next;
  logic [TW-1:0]          w_high;

  assign w_cap_last  = regCtrl32bit ? CAP32_LAST : CAP8_LAST;
  assign w_end_idx   = (regCtrlLimit && (regMax < w_cap_last)) ? BUFFER_BITS'(regMax)
                                                               : BUFFER_BITS'(w_cap_last);
  assign w_bit_val   = r_shift[r_bit];
  assign w_tick_next = r_tick + 1'b1;
  assign w_high      = w_bit_val ? T1_TICKS : T0_TICKS;

  assign ram.pixelIndexComb = r_mode ? BUFFER_BITS'({r_elem, 2'b00}) : r_elem;

  // r_hold keeps IDLE from sampling pixelVal before the RAM has seen address 0
  // after an abort; the normal LATCH path clears the address early enough.
  always_ff @(posedge busClk) begin
    if (syncReset || regCtrlInit) begin
      r_state      <= S_IDLE;
      r_tick       <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_lcnt       <= '0;
      r_elem       <= '0;
      r_end        <= '0;
      r_mode       <= 1'b0;
      r_last       <= 1'b0;
      r_hold       <= 1'b1;
      neoData      <= 1'b0;
      streamSyncOf <= 1'b0;
      state        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_elem <= '0;
          r_last <= 1'b0;
          r_hold <= 1'b0;
          if (regCtrlRun && !r_hold) begin
            r_mode  <= regCtrl32bit;
            r_end   <= w_end_idx;
            r_shift <= ram.pixelVal;
            r_tick  <= '0;
            r_bit   <= 3'd7;
            neoData <= 1'b1;
            state   <= 1'b1;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          // Advance early so the next byte is read well before the last tick.
          if ((r_bit == 3'd0) && (r_tick == '0)) begin
            if (r_elem == r_end) r_last <= 1'b1;
            else                 r_elem <= r_elem + 1'b1;
          end
          if (r_tick == TICK_LAST) begin
            r_tick <= '0;
            if (r_bit == 3'd0) begin
              if (r_last) begin
                r_state      <= S_LATCH;
                r_elem       <= '0;
                r_lcnt       <= '0;
                neoData      <= 1'b0;
                streamSyncOf <= (RESET_TICKS == 1);
              end else begin
                r_shift <= ram.pixelVal;
                r_bit   <= 3'd7;
                neoData <= 1'b1;
              end
            end else begin
              r_bit   <= r_bit - 3'd1;
              neoData <= 1'b1;
            end
          end else begin
            r_tick  <= w_tick_next;
            neoData <= (w_tick_next < w_high);
          end
        end
        S_LATCH: begin
          r_lcnt       <= r_lcnt + 1'b1;
          streamSyncOf <= (r_lcnt == LATCH_PRE);
          if (r_lcnt == LATCH_LAST) begin
            r_state      <= S_IDLE;
            r_lcnt       <= '0;
            streamSyncOf <= 1'b0;
            state        <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_anton_neopixel_stream_serializer.sv
// tb/tb_anton_neopixel_stream_serializer.sv - scoreboard bench for the neopixel serializer
// Expected pulse widths, addresses and frame lengths are queued at issue time.
module tb_anton_neopixel_stream_serializer;
  localparam int BE = 15;
  localparam int BT = 9;
  localparam int T0 = 3;
  localparam int T1 = 6;
  localparam int RT = 400;

  logic        busClk = 1'b0;
  logic        syncReset = 1'b1;
  logic [12:0] regMax = '0;
  logic        regCtrlInit = 1'b0;
  logic        regCtrlLimit = 1'b0;
  logic        regCtrlRun = 1'b0;
  logic        regCtrl32bit = 1'b0;
  logic        neoData;
  logic        streamSyncOf;
  logic        state;

  logic [7:0]  mem [0:BE];
  int          n_tests = 0;
  int          n_fail = 0;
  int          q_width[$];
  int          q_len[$];
  int          q_addr[$];
  bit          mon_hold = 1'b1;

  always #5 busClk = ~busClk;

  anton_neopixel_stream_serializer_if #(.BUFFER_END(BE)) ram_if ();

  anton_neopixel_stream_serializer #(
    .BUFFER_END(BE), .BIT_TICKS(BT), .T0H(T0), .T1H(T1), .RESET_TICKS(RT)
  ) dut (
    .busClk(busClk), .syncReset(syncReset), .ram(ram_if.master),
    .regMax(regMax), .regCtrlInit(regCtrlInit), .regCtrlLimit(regCtrlLimit),
    .regCtrlRun(regCtrlRun), .regCtrl32bit(regCtrl32bit),
    .neoData(neoData), .streamSyncOf(streamSyncOf), .state(state)
  );

  always @(posedge busClk) ram_if.pixelVal <= mem[ram_if.pixelIndexComb];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name, input int got);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0d with nothing expected", name, got);
  endtask

  // Reference: a frame is every element up to the clamped end index, each byte MSB first.
  task automatic push_frame(input bit m32, input bit lim, input int rmax);
    int cap, endi, a;
    cap  = m32 ? (BE >> 2) + 1 : BE + 1;
    endi = cap - 1;
    if (lim && rmax < endi) endi = rmax;
    for (int i = 0; i <= endi; i++) begin
      a = m32 ? 4 * i : i;
      for (int k = 7; k >= 0; k--) q_width.push_back(mem[a][k] ? T1 : T0);
      if (i > 0) q_addr.push_back(a);
    end
    q_len.push_back((endi + 1) * 8 * BT + RT);
  endtask

  int          hi_cnt = 0;
  int          st_cnt = 0;
  logic [3:0]  prev_addr = '0;

  always @(negedge busClk) begin
    if (mon_hold) begin
      hi_cnt    = 0;
      st_cnt    = 0;
      prev_addr = ram_if.pixelIndexComb;
    end else begin
      if (neoData === 1'b1) hi_cnt++;
      else if (hi_cnt > 0) begin
        if (q_width.size() == 0) fail_now("extra_pulse", hi_cnt);
        else check("high_width", hi_cnt, q_width.pop_front());
        hi_cnt = 0;
      end
      if (state === 1'b1) st_cnt++;
      if (streamSyncOf === 1'b1) begin
        if (q_len.size() == 0) fail_now("extra_sync", st_cnt);
        else check("frame_len", st_cnt, q_len.pop_front());
        st_cnt = 0;
      end
      if (ram_if.pixelIndexComb !== prev_addr) begin
        prev_addr = ram_if.pixelIndexComb;
        if (prev_addr != 0) begin
          if (q_addr.size() == 0) fail_now("extra_addr", prev_addr);
          else check("addr", prev_addr, q_addr.pop_front());
        end
      end
    end
  end

  task automatic fill_mem();
    for (int i = 0; i <= BE; i++) mem[i] = 8'($urandom);
  endtask

  task automatic start_frame(input bit m32, input bit lim, input int rmax, input string tag);
    @(posedge busClk); #1;
    regCtrl32bit = m32;
    regCtrlLimit = lim;
    regMax       = 13'(rmax);
    regCtrlRun   = 1'b1;
    @(posedge busClk); #1;
    regCtrlRun = 1'b0;
    check({tag, "_start_state"}, state, 1);
    check({tag, "_start_high"}, neoData, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (state !== 1'b0 && n < 3000) begin
      @(negedge busClk);
      n++;
    end
    if (n >= 3000) fail_now({tag, "_idle_timeout"}, n);
    check({tag, "_queues_drained"}, q_width.size() + q_len.size() + q_addr.size(), 0);
    repeat (2) @(posedge busClk);
  endtask

  task automatic run_frame(input bit m32, input bit lim, input int rmax, input string tag);
    @(posedge busClk); #1;
    push_frame(m32, lim, rmax);
    start_frame(m32, lim, rmax, tag);
    wait_idle(tag);
  endtask

  task automatic count_quiet(input int cycles, input string tag);
    int syncs, busy;
    syncs = 0;
    busy  = 0;
    repeat (cycles) begin
      @(negedge busClk);
      if (streamSyncOf !== 1'b0) syncs++;
      if (state !== 1'b0 || neoData !== 1'b0) busy++;
    end
    check({tag, "_no_sync"}, syncs, 0);
    check({tag, "_stays_idle"}, busy, 0);
  endtask

  initial begin
    int c;
    fill_mem();
    repeat (3) @(posedge busClk); #1;
    check("reset_state", state, 0);
    check("reset_neo", neoData, 0);
    check("reset_sync", streamSyncOf, 0);
    check("reset_addr", ram_if.pixelIndexComb, 0);
    syncReset = 1'b0;
    mon_hold  = 1'b0;
    repeat (3) @(posedge busClk);

    mem[0] = 8'hA5;
    mem[1] = 8'h01;
    run_frame(1'b0, 1'b1, 1, "byte_limit");

    fill_mem();
    run_frame(1'b1, 1'b1, 2, "word_mode");

    fill_mem();
    run_frame(1'b0, 1'b0, 0, "limit_off");
    run_frame(1'b0, 1'b1, 8191, "clamp_max");
    run_frame(1'b1, 1'b1, 8191, "clamp_word");

    for (int it = 0; it < 6; it++) begin
      fill_mem();
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 20), "random");
    end

    fill_mem();
    @(posedge busClk); #1;
    push_frame(1'b0, 1'b1, 2);
    push_frame(1'b0, 1'b1, 2);
    regCtrl32bit = 1'b0;
    regCtrlLimit = 1'b1;
    regMax       = 13'd2;
    regCtrlRun   = 1'b1;
    c = 0;
    do begin
      @(negedge busClk);
      c++;
    end while (streamSyncOf !== 1'b1 && c < 3000);
    if (c >= 3000) fail_now("loop_sync_timeout", c);
    c = 0;
    do begin
      @(negedge busClk);
      c++;
    end while (neoData !== 1'b1 && c < 10);
    check("loop_restart_gap", c, 2);
    regCtrlRun = 1'b0;
    wait_idle("loop");
    count_quiet(40, "loop_stop");

    mon_hold = 1'b1;
    start_frame(1'b0, 1'b1, 3, "init_abort");
    repeat (37) @(posedge busClk); #1;
    regCtrlInit = 1'b1;
    @(posedge busClk); #1;
    check("init_state", state, 0);
    check("init_neo", neoData, 0);
    regCtrlInit = 1'b0;
    count_quiet(600, "init_abort");

    start_frame(1'b0, 1'b1, 0, "reset_abort");
    repeat (8 * BT + 50) @(posedge busClk); #1;
    check("latch_state", state, 1);
    check("latch_neo", neoData, 0);
    syncReset = 1'b1;
    @(posedge busClk); #1;
    check("rst_state", state, 0);
    check("rst_neo", neoData, 0);
    check("rst_sync", streamSyncOf, 0);
    syncReset = 1'b0;
    count_quiet(500, "reset_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
